gray_p_rx: RTL and testbench

//  Receiving end of the gray_p counter interface. Samples a Gray-coded count
//  and decodes it to binary with one cycle of latency. Checks that each new

---
 rtl/gray_p_rx.sv | 129 ++++++++++++
 tb/tb_gray_p_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gray_p_rx.sv
// Gray-coded counter receiver: decodes to binary, tracks neighbour-step legality, counts violations.
// Optional direction/wrap outputs are enabled by defining GRAY_P_RX_DIR_EN.
module gray_p_rx #(
  parameter int N          = 4,
  parameter int ERR_W      = 8,
  parameter int ALLOW_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             g_valid,
  input  logic [N-1:0]     g_in,
  output logic [N-1:0]     bin_out,
  output logic             bin_valid,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked,
  output logic             dir,
  output logic             wrap
);

  typedef enum logic {ACQ, TRACK} state_t;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    if (c == {ERR_W{1'b1}}) return c;
    return c + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [N-1:0]       ref_q, ref_d;
  logic               bv_q, bv_d;
  logic               se_q, se_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [N-1:0]       b_new;
  logic [N-1:0]       delta;
  logic               legal;
  logic               accept_track;

  always_comb begin
    b_new        = gray2bin(g_in);
    delta        = b_new - ref_q;
    legal        = (delta == N'(1)) || (delta == {N{1'b1}}) ||
                   ((ALLOW_HOLD != 0) && (delta == '0));
    accept_track = !clr && g_valid && (state_q == TRACK);
    state_d      = state_q;
    ref_d        = ref_q;
    bv_d         = 1'b0;
    se_d         = 1'b0;
    err_d        = err_q;
    // clr takes priority and discards any same-cycle sample
    if (clr) begin
      state_d = ACQ;
      err_d   = '0;
    end else if (g_valid) begin
      ref_d   = b_new;
      bv_d    = 1'b1;
      state_d = TRACK;
      if (state_q == TRACK && !legal) begin
        se_d  = 1'b1;
        err_d = sat_inc(err_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACQ;
      ref_q   <= '0;
      bv_q    <= 1'b0;
      se_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      bv_q    <= bv_d;
      se_q    <= se_d;
      err_q   <= err_d;
    end
  end

  assign bin_out   = ref_q;
  assign bin_valid = bv_q;
  assign step_err  = se_q;
  assign err_cnt   = err_q;
  assign locked    = (state_q == TRACK);

`ifdef GRAY_P_RX_DIR_EN
  logic dir_q, dir_d;
  logic wrap_q, wrap_d;

  // Up takes precedence so N=1 (where +1 and -1 coincide) reads as up
  always_comb begin
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (accept_track && legal) begin
      if (delta == N'(1))             dir_d = 1'b1;
      else if (delta == {N{1'b1}})    dir_d = 1'b0;
      wrap_d = ((ref_q == {N{1'b1}}) && (b_new == '0)) ||
               ((ref_q == '0) && (b_new == {N{1'b1}}));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  assign dir  = dir_q;
  assign wrap = wrap_q;
`else
  logic unused_track;
  assign unused_track = accept_track;
  assign dir  = 1'b0;
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_gray_p_rx.sv
// Directed, table-driven bench for gray_p_rx: default instance (N=4, ERR_W=8, hold legal)
// and a strict instance (ALLOW_HOLD=0, ERR_W=2) for hold errors and saturation.
module tb_gray_p_rx;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [3:0] g;
    logic [3:0] bin;
    logic       bv;
    logic       se;
    int         err;
    logic       lk;
    logic       dir;
    logic       wrap;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_clr, a_vld;
  logic [3:0] a_g, a_bin;
  logic       a_bv, a_se, a_lk, a_dir, a_wrap;
  logic [7:0] a_err;

  logic       b_clr, b_vld;
  logic [3:0] b_g, b_bin;
  logic       b_bv, b_se, b_lk, b_dir, b_wrap;
  logic [1:0] b_err;

  int errors = 0;
  int checks = 0;

  gray_p_rx #(.N(4), .ERR_W(8), .ALLOW_HOLD(1)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .g_valid(a_vld), .g_in(a_g),
    .bin_out(a_bin), .bin_valid(a_bv), .step_err(a_se), .err_cnt(a_err),
    .locked(a_lk), .dir(a_dir), .wrap(a_wrap)
  );

  gray_p_rx #(.N(4), .ERR_W(2), .ALLOW_HOLD(0)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .g_valid(b_vld), .g_in(b_g),
    .bin_out(b_bin), .bin_valid(b_bv), .step_err(b_se), .err_cnt(b_err),
    .locked(b_lk), .dir(b_dir), .wrap(b_wrap)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic vec_t mk(input logic c, input logic v, input logic [3:0] g,
                              input logic [3:0] bin, input logic bv, input logic se,
                              input int err, input logic lk, input logic d, input logic w);
    vec_t r;
    r.clr = c; r.vld = v; r.g = g; r.bin = bin; r.bv = bv; r.se = se;
    r.err = err; r.lk = lk; r.dir = d; r.wrap = w;
    return r;
  endfunction

  task automatic apply_a(input vec_t v, input string tag);
    logic ed, ew;
    a_clr = v.clr; a_vld = v.vld; a_g = v.g;
    @(posedge clk); #1;
`ifdef GRAY_P_RX_DIR_EN
    ed = v.dir; ew = v.wrap;
`else
    ed = 1'b0; ew = 1'b0;
`endif
    check({tag, ".bin"},  32'(a_bin), 32'(v.bin));
    check({tag, ".bv"},   32'(a_bv),  32'(v.bv));
    check({tag, ".se"},   32'(a_se),  32'(v.se));
    check({tag, ".err"},  32'(a_err), 32'(v.err));
    check({tag, ".lk"},   32'(a_lk),  32'(v.lk));
    check({tag, ".dir"},  32'(a_dir), 32'(ed));
    check({tag, ".wrap"}, 32'(a_wrap), 32'(ew));
  endtask

  task automatic apply_b(input vec_t v, input string tag);
    b_clr = v.clr; b_vld = v.vld; b_g = v.g;
    @(posedge clk); #1;
    check({tag, ".bin"}, 32'(b_bin), 32'(v.bin));
    check({tag, ".bv"},  32'(b_bv),  32'(v.bv));
    check({tag, ".se"},  32'(b_se),  32'(v.se));
    check({tag, ".err"}, 32'(b_err), 32'(v.err));
    check({tag, ".lk"},  32'(b_lk),  32'(v.lk));
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, ".bin"},  32'(a_bin),  0);
    check({tag, ".bv"},   32'(a_bv),   0);
    check({tag, ".se"},   32'(a_se),   0);
    check({tag, ".err"},  32'(a_err),  0);
    check({tag, ".lk"},   32'(a_lk),   0);
    check({tag, ".dir"},  32'(a_dir),  0);
    check({tag, ".wrap"}, 32'(a_wrap), 0);
    check({tag, ".b_err"}, 32'(b_err), 0);
    check({tag, ".b_lk"},  32'(b_lk),  0);
  endtask

  vec_t va[$];
  vec_t vb[$];
  vec_t vs[$];

  initial begin
    // Default instance: 20-sample up count, illegal jump, resync, hold, clr, ACQ, hold-legal
    for (int i = 0; i < 20; i++)
      va.push_back(mk(0, 1, gray(i % 16), 4'(i % 16), 1, 0, 0, 1, i > 0, i == 16));
    va.push_back(mk(0, 1, 4'b1001, 4'd14, 1, 1, 1, 1, 1, 0));
    va.push_back(mk(0, 1, 4'b1011, 4'd13, 1, 0, 1, 1, 0, 0));
    va.push_back(mk(0, 0, 4'b1011, 4'd13, 0, 0, 1, 1, 0, 0));
    va.push_back(mk(0, 1, 4'b1011, 4'd13, 1, 0, 1, 1, 0, 0));
    va.push_back(mk(1, 1, 4'b0000, 4'd13, 0, 0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 4'b1111, 4'd10, 1, 0, 0, 1, 0, 0));
    va.push_back(mk(0, 1, 4'b0000, 4'd0,  1, 1, 1, 1, 0, 0));
    va.push_back(mk(0, 1, 4'b0110, 4'd4,  1, 1, 2, 1, 0, 0));
    va.push_back(mk(0, 1, 4'b0110, 4'd4,  1, 0, 2, 1, 0, 0));

    // Strict instance: hold error, clr, saturation at 3, clr with valid, legal steps
    vb.push_back(mk(0, 1, 4'b0110, 4'd4,  1, 0, 0, 1, 0, 0));
    vb.push_back(mk(0, 1, 4'b0110, 4'd4,  1, 1, 1, 1, 0, 0));
    vb.push_back(mk(1, 0, 4'b0110, 4'd4,  0, 0, 0, 0, 0, 0));
    vb.push_back(mk(0, 1, 4'b0000, 4'd0,  1, 0, 0, 1, 0, 0));
    vb.push_back(mk(0, 1, 4'b0110, 4'd4,  1, 1, 1, 1, 0, 0));
    vb.push_back(mk(0, 1, 4'b1100, 4'd8,  1, 1, 2, 1, 0, 0));
    vb.push_back(mk(0, 1, 4'b1010, 4'd12, 1, 1, 3, 1, 0, 0));
    vb.push_back(mk(0, 1, 4'b0000, 4'd0,  1, 1, 3, 1, 0, 0));
    vb.push_back(mk(0, 1, 4'b0110, 4'd4,  1, 1, 3, 1, 0, 0));
    vb.push_back(mk(1, 1, 4'b0001, 4'd4,  0, 0, 0, 0, 0, 0));
    vb.push_back(mk(0, 1, 4'b0111, 4'd5,  1, 0, 0, 1, 0, 0));
    vb.push_back(mk(0, 1, 4'b0101, 4'd6,  1, 0, 0, 1, 0, 0));

    // After mid-stream reset: ACQ at 15, wrap up to 0, wrap down to 15, idle
    vs.push_back(mk(0, 1, 4'b1000, 4'd15, 1, 0, 0, 1, 0, 0));
    vs.push_back(mk(0, 1, 4'b0000, 4'd0,  1, 0, 0, 1, 1, 1));
    vs.push_back(mk(0, 1, 4'b1000, 4'd15, 1, 0, 0, 1, 0, 1));
    vs.push_back(mk(0, 0, 4'b1000, 4'd15, 0, 0, 0, 1, 0, 0));

    rst = 1'b0;
    a_clr = 0; a_vld = 0; a_g = '0;
    b_clr = 0; b_vld = 0; b_g = '0;
    #12;
    check_a_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (va[i]) apply_a(va[i], $sformatf("a%0d", i));
    a_vld = 0; a_clr = 0;
    foreach (vb[i]) apply_b(vb[i], $sformatf("b%0d", i));
    b_vld = 0; b_clr = 0;

    // Async reset between samples: outputs clear without a clock edge
    #2 rst = 1'b0;
    #1 check_a_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    foreach (vs[i]) apply_a(vs[i], $sformatf("s%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
